ball_sequencer: RTL and testbench
=================================

BALL_SEQUENCER -- requirements
Module: ball_sequencer

Interface
REQ-001 Parameter LIVES, 3, balls per game; legal range 1..3.
REQ-002 Parameter LAUNCH_FRAMES, 60, frames held in LAUNCH before play; legal range 1..255.
REQ-003 Parameter LEVEL_STEP, 10, scoring hits per level advance; legal range 1..255.
REQ-004 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  one clock; reset is synchronous and active-high.
REQ-006 startFrame  input  1  one-cycle pulse per video frame.
REQ-007 key5IsPressed  input  1  start/launch key, level-sensitive.
REQ-008 collisionSmileyBorderBottom  input  1  ball lost.
REQ-009 collisionSmileyObstacleReal  input  1  one-cycle scoring hit.
REQ-010 pause  output  1  freezes ball motion when high.
REQ-011 reset_level  output  1  one-cycle pulse that re-places the ball.
REQ-012 score  output  8  current game score, binary.
REQ-013 lives  output  2  balls remaining.
REQ-014 level  output  3  current level, 0..7.
REQ-015 game_over  output  1  high while in OVER.
REQ-016 high_score  output  8  best score since reset (see Configuration).

Function
REQ-017 The FSM SHALL have states IDLE, LAUNCH, PLAY, LOST, OVER; all outputs are registered, so every output change appears one cycle after its triggering input.
REQ-018 Key press SHALL mean the rising edge of key5IsPressed, using a registered copy of the previous value; a held key SHALL count as one press.
REQ-019 IDLE: pause=1; on a key press -> LAUNCH with score=0, level=0, hit counter=0, lives=LIVES, and reset_level pulsed.
REQ-020 LAUNCH: pause=1; an 8-bit frame counter SHALL clear on entry and count startFrame pulses; on the LAUNCH_FRAMES-th pulse -> PLAY.
REQ-021 PLAY: pause=0; each hit SHALL increment score, saturating at 255, and increment the hit counter.
REQ-022 When the hit counter reaches LEVEL_STEP it SHALL clear and level SHALL increment, saturating at 7; the counter SHALL still clear at level 7.
REQ-023 PLAY with bottom collision: lives decrements, reset_level is pulsed, and the state goes to OVER if lives was 1, else to LOST.
REQ-024 A hit and a bottom collision in the same cycle: the bottom collision SHALL win and the hit SHALL be discarded.
REQ-025 LOST: pause=1; on a key press -> LAUNCH; score and level SHALL be retained.
REQ-026 OVER: pause=1, game_over=1; score, level and lives (0) are held; a key press SHALL re-initialise exactly as in REQ-019 and go to LAUNCH.
REQ-027 Hits and bottom collisions outside PLAY SHALL be ignored.
REQ-028 reset_level SHALL be high for exactly one cycle per event and low otherwise.

Reset
REQ-029 When reset is high at a clock edge: state=IDLE, pause=1, reset_level=0, score=0, lives=0, level=0, game_over=0, high_score=0, counters cleared, key edge register=0.
REQ-030 Reset mid-game SHALL abandon the game immediately with no reset_level pulse.

Configuration
REQ-031 Macro HIGH_SCORE_EN defined: on each transition into OVER, high_score SHALL load score if score > high_score; high_score is cleared only by reset.
REQ-032 HIGH_SCORE_EN undefined: the high_score register SHALL not exist and the port SHALL be driven constant 0.

Verification
REQ-033 Reset, then key press, then 60 startFrame pulses -> LAUNCH then PLAY; pause falls one cycle after the 60th pulse; lives=3; one reset_level pulse at start.
REQ-034 In PLAY, 10 hits -> score=10, level=1; 255+5 hits -> score=255 saturated; level saturated at 7.
REQ-035 Hit and bottom collision in the same cycle with score=4, lives=3 -> score=4, lives=2, state LOST, one reset_level pulse.
REQ-036 Three ball losses -> OVER, game_over=1, lives=0; with HIGH_SCORE_EN and score=37, high_score=37; a next game scoring 20 leaves high_score=37.
REQ-037 Key held high across LOST for 100 cycles -> exactly one LAUNCH entry; reset asserted during PLAY -> IDLE next cycle with all outputs at reset values.

Source files
------------

// File: rtl/ball_sequencer_if.sv
// Frame-level signal bundle between the game core and the ball sequencer.
// The master side drives frame/key/collision events; the slave side reports game state.
interface ball_sequencer_if;
   logic       startFrame;
   logic       key5IsPressed;
   logic       collisionSmileyBorderBottom;
   logic       collisionSmileyObstacleReal;
   logic       pause;
   logic       reset_level;
   logic [7:0] score;
   logic [1:0] lives;
   logic [2:0] level;
   logic       game_over;
   logic [7:0] high_score;

   modport master (
      output startFrame, key5IsPressed, collisionSmileyBorderBottom, collisionSmileyObstacleReal,
      input  pause, reset_level, score, lives, level, game_over, high_score
   );

   modport slave (
      input  startFrame, key5IsPressed, collisionSmileyBorderBottom, collisionSmileyObstacleReal,
      output pause, reset_level, score, lives, level, game_over, high_score
   );
endinterface

// File: rtl/ball_sequencer.sv
// Game flow FSM: IDLE -> LAUNCH -> PLAY -> LOST/OVER, with score, level and lives tracking.
// Optional HIGH_SCORE_EN macro keeps a best-score register; otherwise high_score is tied to 0.
module ball_sequencer #(
   parameter int LIVES         = 3,
   parameter int LAUNCH_FRAMES = 60,
   parameter int LEVEL_STEP    = 10
) (
   input  logic              clk,
   input  logic              reset,
   ball_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {IDLE, LAUNCH, PLAY, LOST, OVER} state_t;

   localparam logic [8:0] LF_C    = 9'(LAUNCH_FRAMES);
   localparam logic [8:0] LS_C    = 9'(LEVEL_STEP);
   localparam logic [1:0] LIVES_C = 2'(LIVES);

   state_t     state_q, state_d;
   logic [7:0] score_q, score_d;
   logic [1:0] lives_q, lives_d;
   logic [2:0] level_q, level_d;
   logic [7:0] frame_q, frame_d;
   logic [7:0] hits_q, hits_d;
   logic       key_prev_q;
   logic       pause_q, pause_d;
   logic       rl_q, rl_d;
   logic       over_q, over_d;
   logic       key_press;

   assign key_press = bus.key5IsPressed & ~key_prev_q;

   always_comb begin
      state_d = state_q;
      score_d = score_q;
      lives_d = lives_q;
      level_d = level_q;
      frame_d = frame_q;
      hits_d  = hits_q;
      rl_d    = 1'b0;
      case (state_q)
         IDLE, OVER: begin
            if (key_press) begin
               state_d = LAUNCH;
               score_d = '0;
               level_d = '0;
               hits_d  = '0;
               frame_d = '0;
               lives_d = LIVES_C;
               rl_d    = 1'b1;
            end
         end
         LAUNCH: begin
            if (bus.startFrame) begin
               if ({1'b0, frame_q} + 9'd1 == LF_C) state_d = PLAY;
               else                                frame_d = frame_q + 8'd1;
            end
         end
         PLAY: begin
            // A bottom collision wins over a simultaneous hit.
            if (bus.collisionSmileyBorderBottom) begin
               lives_d = lives_q - 2'd1;
               rl_d    = 1'b1;
               state_d = (lives_q == 2'd1) ? OVER : LOST;
            end else if (bus.collisionSmileyObstacleReal) begin
               if (score_q != 8'hff) score_d = score_q + 8'd1;
               if ({1'b0, hits_q} + 9'd1 == LS_C) begin
                  hits_d = '0;
                  if (level_q != 3'd7) level_d = level_q + 3'd1;
               end else begin
                  hits_d = hits_q + 8'd1;
               end
            end
         end
         LOST: begin
            if (key_press) begin
               state_d = LAUNCH;
               frame_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      pause_d = (state_d != PLAY);
      over_d  = (state_d == OVER);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         score_q    <= '0;
         lives_q    <= '0;
         level_q    <= '0;
         frame_q    <= '0;
         hits_q     <= '0;
         key_prev_q <= 1'b0;
         pause_q    <= 1'b1;
         rl_q       <= 1'b0;
         over_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         score_q    <= score_d;
         lives_q    <= lives_d;
         level_q    <= level_d;
         frame_q    <= frame_d;
         hits_q     <= hits_d;
         key_prev_q <= bus.key5IsPressed;
         pause_q    <= pause_d;
         rl_q       <= rl_d;
         over_q     <= over_d;
      end
   end

`ifdef HIGH_SCORE_EN
   logic [7:0] hs_q, hs_d;

   // Score is stable across the losing collision, so score_q is the final game score.
   always_comb begin
      hs_d = hs_q;
      if (state_q == PLAY && state_d == OVER && score_q > hs_q) hs_d = score_q;
   end

   always_ff @(posedge clk) begin
      if (reset) hs_q <= '0;
      else       hs_q <= hs_d;
   end

   assign bus.high_score = hs_q;
`else
   assign bus.high_score = '0;
`endif

   assign bus.pause       = pause_q;
   assign bus.reset_level = rl_q;
   assign bus.score       = score_q;
   assign bus.lives       = lives_q;
   assign bus.level       = level_q;
   assign bus.game_over   = over_q;

endmodule

// File: tb/tb_ball_sequencer.sv
// Directed bench for ball_sequencer: game start, launch timing, scoring, losses, game over, reset.
module tb_ball_sequencer;

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_err = 0;
   int   rl_cnt = 0;
   int   hs_exp;

   ball_sequencer_if bus ();

   ball_sequencer #(.LIVES(3), .LAUNCH_FRAMES(60), .LEVEL_STEP(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.reset_level === 1'b1) rl_cnt++;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press();
      bus.key5IsPressed = 1'b1;
      tick();
      bus.key5IsPressed = 1'b0;
      tick();
   endtask

   task automatic launch(input string tag);
      for (int i = 0; i < 60; i++) begin
         bus.startFrame = 1'b1;
         tick();
         bus.startFrame = 1'b0;
         if (i == 58) chk({tag, "_pause_59"}, int'(bus.pause), 1);
         if (i == 59) chk({tag, "_pause_60"}, int'(bus.pause), 0);
         tick();
      end
   endtask

   task automatic hits(input int n);
      bus.collisionSmileyObstacleReal = 1'b1;
      repeat (n) tick();
      bus.collisionSmileyObstacleReal = 1'b0;
      tick();
   endtask

   task automatic lose();
      bus.collisionSmileyBorderBottom = 1'b1;
      tick();
      bus.collisionSmileyBorderBottom = 1'b0;
      tick();
   endtask

   initial begin
`ifdef HIGH_SCORE_EN
      hs_exp = 37;
`else
      hs_exp = 0;
`endif
      reset = 1'b1;
      bus.startFrame = 1'b0;
      bus.key5IsPressed = 1'b0;
      bus.collisionSmileyBorderBottom = 1'b0;
      bus.collisionSmileyObstacleReal = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_pause", int'(bus.pause), 1);
      chk("rst_score", int'(bus.score), 0);
      chk("rst_lives", int'(bus.lives), 0);
      chk("rst_over",  int'(bus.game_over), 0);
      chk("rst_rl",    int'(bus.reset_level), 0);
      chk("rst_hs",    int'(bus.high_score), 0);

      // Game 1: start, launch, lose with simultaneous hit
      bus.key5IsPressed = 1'b1;
      tick();
      chk("start_rl", int'(bus.reset_level), 1);
      chk("start_lives", int'(bus.lives), 3);
      bus.key5IsPressed = 1'b0;
      tick();
      chk("start_rl_low", int'(bus.reset_level), 0);
      launch("g1");
      chk("g1_rlcnt", rl_cnt, 1);
      hits(4);
      chk("g1_score4", int'(bus.score), 4);
      bus.collisionSmileyObstacleReal = 1'b1;
      bus.collisionSmileyBorderBottom = 1'b1;
      tick();
      bus.collisionSmileyObstacleReal = 1'b0;
      bus.collisionSmileyBorderBottom = 1'b0;
      chk("both_score", int'(bus.score), 4);
      chk("both_lives", int'(bus.lives), 2);
      chk("both_pause", int'(bus.pause), 1);
      chk("both_rl", int'(bus.reset_level), 1);
      tick();
      chk("both_rlcnt", rl_cnt, 2);

      // Key held through LOST and the relaunch
      bus.key5IsPressed = 1'b1;
      repeat (40) tick();
      chk("hold_pause", int'(bus.pause), 1);
      launch("hold");
      bus.key5IsPressed = 1'b0;
      chk("hold_score", int'(bus.score), 4);
      chk("hold_lives", int'(bus.lives), 2);
      chk("hold_rlcnt", rl_cnt, 2);

      hits(33);
      chk("g1_score37", int'(bus.score), 37);
      lose();
      chk("g1_lives1", int'(bus.lives), 1);
      press();
      launch("g1b");
      lose();
      chk("over_lives", int'(bus.lives), 0);
      chk("over_flag", int'(bus.game_over), 1);
      chk("over_pause", int'(bus.pause), 1);
      chk("over_hs", int'(bus.high_score), hs_exp);
      chk("over_rlcnt", rl_cnt, 4);
      hits(1);
      lose();
      chk("over_ign_score", int'(bus.score), 37);
      chk("over_ign_lives", int'(bus.lives), 0);

      // Game 2: restart from OVER
      press();
      chk("g2_score", int'(bus.score), 0);
      chk("g2_level", int'(bus.level), 0);
      chk("g2_lives", int'(bus.lives), 3);
      chk("g2_over", int'(bus.game_over), 0);
      chk("g2_rlcnt", rl_cnt, 5);
      hits(1);
      chk("launch_ign_hit", int'(bus.score), 0);
      launch("g2");
      hits(10);
      chk("g2_score10", int'(bus.score), 10);
      chk("g2_level1", int'(bus.level), 1);
      hits(10);
      chk("g2_score20", int'(bus.score), 20);
      chk("g2_level2", int'(bus.level), 2);
      lose(); press(); launch("g2b");
      lose(); press(); launch("g2c");
      lose();
      chk("g2_over", int'(bus.game_over), 1);
      chk("g2_final", int'(bus.score), 20);
      chk("g2_hs", int'(bus.high_score), hs_exp);

      // Game 3: saturation, then reset mid-play
      press();
      launch("g3");
      hits(260);
      chk("sat_score", int'(bus.score), 255);
      chk("sat_level", int'(bus.level), 7);
      chk("sat_lives", int'(bus.lives), 3);
      rl_cnt = 0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_pause", int'(bus.pause), 1);
      chk("mid_rst_score", int'(bus.score), 0);
      chk("mid_rst_lives", int'(bus.lives), 0);
      chk("mid_rst_level", int'(bus.level), 0);
      chk("mid_rst_over", int'(bus.game_over), 0);
      chk("mid_rst_hs", int'(bus.high_score), 0);
      tick();
      chk("mid_rst_rlcnt", rl_cnt, 0);
      chk("idle_pause", int'(bus.pause), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
